id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file, immediate generation, operand forwarding, hazard interlock and EX payload register.
// Optional feature macro: ID_FORWARDING_EN (EX/MEM forwarding; without it every RAW hazard stalls until the WB bypass).
module id_stage_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_op_a_o,
  output logic [DATA_WIDTH-1:0] ex_op_b_o,
  output logic [DATA_WIDTH-1:0] ex_store_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [ADDR_WIDTH-1:0] ex_rd_o,
  output logic [3:0]            ex_alu_op_o,
  output logic                  ex_reg_we_o,
  output logic                  ex_mem_we_o,
  output logic                  ex_mem_re_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  ex_illegal_o,
  input  logic [DATA_WIDTH-1:0] ex_fwd_data_i,
  input  logic                  mem_fwd_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] rd;
    logic [3:0]            alu_op;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } ex_payload_t;

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  ex_payload_t           ex_q, ex_d, dec;
  logic                  ex_valid_q, ex_valid_d;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rs1_f, rs2_f, rd_f;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                  use_rs1, use_rs2, writes_rd, legal_opc, stall;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd_f   = instr_i[11:7];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];

  assign imm_i = DATA_WIDTH'($signed(instr_i[31:20]));
  assign imm_s = DATA_WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b = DATA_WIDTH'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
  assign imm_u = DATA_WIDTH'($signed({instr_i[31:12], 12'h000}));
  assign imm_j = DATA_WIDTH'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

  // Source operand value: x0, then the youngest in-flight producer, then the register file with WB bypass.
  function automatic logic [DATA_WIDTH-1:0] read_src(input logic [4:0] field);
    logic [ADDR_WIDTH-1:0] idx;
    idx = ADDR_WIDTH'(field);
    if (field == 5'd0 || 32'(field) >= NUM_REGS) return '0;
`ifdef ID_FORWARDING_EN
    if (ex_valid_q && ex_q.reg_we && !ex_q.mem_re && ex_q.rd == idx) return ex_fwd_data_i;
    if (mem_fwd_we_i && mem_fwd_rd_i == idx) return mem_fwd_data_i;
`endif
    if (wb_we_i && wb_waddr_i == idx) return wb_wdata_i;
    return rf_q[idx];
  endfunction

  // A source that cannot be supplied this cycle forces a bubble.
  function automatic logic src_hazard(input logic [4:0] field);
    logic [ADDR_WIDTH-1:0] idx;
    logic                  hit;
    idx = ADDR_WIDTH'(field);
    hit = 1'b0;
    if (field != 5'd0 && 32'(field) < NUM_REGS) begin
      hit = ex_valid_q && ex_q.mem_re && ex_q.rd == idx;
`ifndef ID_FORWARDING_EN
      hit = hit || (ex_valid_q && ex_q.reg_we && ex_q.rd == idx) ||
            (mem_fwd_we_i && mem_fwd_rd_i == idx);
`endif
    end
    return hit;
  endfunction

`ifndef ID_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_data_i, mem_fwd_data_i};
`endif

  always_comb begin
    dec       = '0;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    legal_opc = 1'b1;
    dec.pc    = pc_i;
    dec.rd    = ADDR_WIDTH'(rd_f);
    case (opcode)
      OPC_OP: begin
        writes_rd  = 1'b1;
        use_rs2    = 1'b1;
        dec.alu_op = {instr_i[30], funct3};
      end
      OPC_OPIMM: begin
        writes_rd  = 1'b1;
        dec.imm    = imm_i;
        dec.alu_op = {(funct3 == 3'b101) && instr_i[30], funct3};
      end
      OPC_LOAD: begin
        writes_rd  = 1'b1;
        dec.mem_re = 1'b1;
        dec.imm    = imm_i;
      end
      OPC_STORE: begin
        use_rs2    = 1'b1;
        dec.mem_we = 1'b1;
        dec.imm    = imm_s;
      end
      OPC_BRANCH: begin
        use_rs2    = 1'b1;
        dec.branch = 1'b1;
        dec.imm    = imm_b;
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b0;
        dec.jump  = 1'b1;
        dec.imm   = imm_j;
      end
      OPC_JALR: begin
        writes_rd = 1'b1;
        dec.jump  = 1'b1;
        dec.imm   = imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b0;
        dec.imm   = imm_u;
      end
      default: legal_opc = 1'b0;
    endcase
    dec.reg_we  = writes_rd;
    dec.illegal = !legal_opc ||
                  (use_rs1 && 32'(rs1_f) >= NUM_REGS) ||
                  (use_rs2 && 32'(rs2_f) >= NUM_REGS) ||
                  (writes_rd && 32'(rd_f) >= NUM_REGS);
    if (dec.illegal) begin
      dec.reg_we = 1'b0;
      dec.mem_we = 1'b0;
      dec.mem_re = 1'b0;
    end
    if (opcode == OPC_AUIPC || opcode == OPC_JAL) dec.op_a = pc_i;
    else if (opcode == OPC_LUI)                   dec.op_a = '0;
    else                                          dec.op_a = read_src(rs1_f);
    dec.op_b       = (opcode == OPC_OP || opcode == OPC_BRANCH) ? read_src(rs2_f) : dec.imm;
    dec.store_data = read_src(rs2_f);
  end

  assign stall      = (use_rs1 && src_hazard(rs1_f)) || (use_rs2 && src_hazard(rs2_f));
  assign if_ready_o = !rst_i && (flush_i || (!stall && (!ex_valid_q || ex_ready_i)));

  // Flush kills the slot; otherwise the slot refills whenever it is empty or being consumed.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (!ex_valid_q || ex_ready_i) begin
      ex_valid_d = if_valid_i && !stall;
      if (ex_valid_d) ex_d = dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_we_i && wb_waddr_i != '0 && 32'(wb_waddr_i) < NUM_REGS) begin
      rf_q[wb_waddr_i] <= wb_wdata_i;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign ex_op_a_o       = ex_q.op_a;
  assign ex_op_b_o       = ex_q.op_b;
  assign ex_store_data_o = ex_q.store_data;
  assign ex_imm_o        = ex_q.imm;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rd_o         = ex_q.rd;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_reg_we_o     = ex_q.reg_we;
  assign ex_mem_we_o     = ex_q.mem_we;
  assign ex_mem_re_o     = ex_q.mem_re;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_illegal_o    = ex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against an architectural reference model.
module tb_id_stage_pipe;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111,
                         AUIPC = 7'b0010111;

  typedef struct packed {
    logic        valid;
    logic [31:0] op_a, op_b, sd, imm, pc;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        reg_we, mem_we, mem_re, br, jmp, ill;
  } ex_t;

  logic        clk, rst, if_valid, flush, ex_ready, mem_fwd_we, wb_we;
  logic [31:0] instr, pc, ex_fwd_data, mem_fwd_data, wb_wdata;
  logic [4:0]  mem_fwd_rd, wb_waddr;

  logic        if_ready, ex_valid, ex_reg_we, ex_mem_we, ex_mem_re, ex_br, ex_jmp, ex_ill;
  logic [31:0] ex_op_a, ex_op_b, ex_sd, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu;

  logic        if_ready16, ex_valid16, ex_reg_we16, ex_mem_we16, ex_mem_re16, ex_br16, ex_jmp16, ex_ill16;
  logic [31:0] ex_op_a16, ex_op_b16, ex_sd16, ex_imm16, ex_pc16;
  logic [3:0]  ex_rd16;
  logic [3:0]  ex_alu16;

  ex_t         m_ex;
  logic [31:0] m_rf [32];
  logic        exp_ready, act_ready;
  int          n_vec, n_err;

  id_stage_pipe dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready), .instr_i(instr),
    .pc_i(pc), .flush_i(flush), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_op_a_o(ex_op_a), .ex_op_b_o(ex_op_b), .ex_store_data_o(ex_sd), .ex_imm_o(ex_imm),
    .ex_pc_o(ex_pc), .ex_rd_o(ex_rd), .ex_alu_op_o(ex_alu), .ex_reg_we_o(ex_reg_we),
    .ex_mem_we_o(ex_mem_we), .ex_mem_re_o(ex_mem_re), .ex_branch_o(ex_br), .ex_jump_o(ex_jmp),
    .ex_illegal_o(ex_ill), .ex_fwd_data_i(ex_fwd_data), .mem_fwd_we_i(mem_fwd_we),
    .mem_fwd_rd_i(mem_fwd_rd), .mem_fwd_data_i(mem_fwd_data), .wb_we_i(wb_we),
    .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata)
  );

  id_stage_pipe #(.NUM_REGS(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready16), .instr_i(instr),
    .pc_i(pc), .flush_i(flush), .ex_valid_o(ex_valid16), .ex_ready_i(ex_ready),
    .ex_op_a_o(ex_op_a16), .ex_op_b_o(ex_op_b16), .ex_store_data_o(ex_sd16), .ex_imm_o(ex_imm16),
    .ex_pc_o(ex_pc16), .ex_rd_o(ex_rd16), .ex_alu_op_o(ex_alu16), .ex_reg_we_o(ex_reg_we16),
    .ex_mem_we_o(ex_mem_we16), .ex_mem_re_o(ex_mem_re16), .ex_branch_o(ex_br16), .ex_jump_o(ex_jmp16),
    .ex_illegal_o(ex_ill16), .ex_fwd_data_i(ex_fwd_data), .mem_fwd_we_i(mem_fwd_we),
    .mem_fwd_rd_i(mem_fwd_rd[3:0]), .mem_fwd_data_i(mem_fwd_data), .wb_we_i(wb_we),
    .wb_waddr_i(wb_waddr[3:0]), .wb_wdata_i(wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of a source register as seen by the instruction in ID.
  function automatic logic [31:0] src_ref(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef ID_FORWARDING_EN
    if (m_ex.valid && m_ex.reg_we && !m_ex.mem_re && m_ex.rd == idx) return ex_fwd_data;
    if (mem_fwd_we && mem_fwd_rd == idx) return mem_fwd_data;
`endif
    if (wb_we && wb_waddr == idx) return wb_wdata;
    return m_rf[idx];
  endfunction

  function automatic logic hz_ref(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    if (m_ex.valid && m_ex.mem_re && m_ex.rd == idx) return 1'b1;
`ifndef ID_FORWARDING_EN
    if (m_ex.valid && m_ex.reg_we && m_ex.rd == idx) return 1'b1;
    if (mem_fwd_we && mem_fwd_rd == idx) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic stall_ref(input logic [31:0] ins);
    logic [6:0] o;
    logic       u1, u2;
    o  = ins[6:0];
    u1 = !(o == LUI || o == AUIPC || o == JAL);
    u2 = (o == OP || o == ST || o == BR);
    return (u1 && hz_ref(ins[19:15])) || (u2 && hz_ref(ins[24:20]));
  endfunction

  function automatic ex_t decode_ref(input logic [31:0] ins, input logic [31:0] p);
    ex_t        e;
    logic [6:0] o;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] immi;
    o    = ins[6:0];
    b13  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    immi = 32'($signed(ins[31:20]));
    e = '0;
    e.valid = 1'b1;
    e.pc = p;
    e.rd = ins[11:7];
    case (o)
      OP:    begin e.reg_we = 1'b1; e.alu = {ins[30], ins[14:12]}; end
      OPI:   begin e.reg_we = 1'b1; e.imm = immi; e.alu = {ins[14:12] == 3'd5 && ins[30], ins[14:12]}; end
      LD:    begin e.reg_we = 1'b1; e.mem_re = 1'b1; e.imm = immi; end
      ST:    begin e.mem_we = 1'b1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      BR:    begin e.br = 1'b1; e.imm = 32'($signed(b13)); end
      JAL:   begin e.reg_we = 1'b1; e.jmp = 1'b1; e.imm = 32'($signed(j21)); end
      JALR:  begin e.reg_we = 1'b1; e.jmp = 1'b1; e.imm = immi; end
      LUI, AUIPC: begin e.reg_we = 1'b1; e.imm = ins[31:12] * 32'd4096; end
      default: e.ill = 1'b1;
    endcase
    e.op_a = (o == AUIPC || o == JAL) ? p : (o == LUI) ? 32'h0 : src_ref(ins[19:15]);
    e.op_b = (o == OP || o == BR) ? src_ref(ins[24:20]) : e.imm;
    e.sd   = src_ref(ins[24:20]);
    return e;
  endfunction

  function automatic ex_t dut_out();
    return '{ex_valid, ex_op_a, ex_op_b, ex_sd, ex_imm, ex_pc, ex_rd, ex_alu,
             ex_reg_we, ex_mem_we, ex_mem_re, ex_br, ex_jmp, ex_ill};
  endfunction

  // One clock with the inputs already driven; advances the model and returns at the next falling edge.
  task automatic cycle();
    ex_t  nx;
    logic st;
    #1;
    st        = stall_ref(instr);
    exp_ready = !rst && (flush || (!st && (!m_ex.valid || ex_ready)));
    act_ready = if_ready;
    nx = m_ex;
    if (rst) nx = '0;
    else if (flush) nx.valid = 1'b0;
    else if (!m_ex.valid || ex_ready) begin
      if (if_valid && !st) nx = decode_ref(instr, pc);
      else nx.valid = 1'b0;
    end
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    else if (wb_we && wb_waddr != 5'd0) m_rf[wb_waddr] = wb_wdata;
    m_ex = nx;
    @(negedge clk);
  endtask

  task automatic quiet();
    flush = 1'b0; mem_fwd_we = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b1; flush = 1'b1; instr = 32'hFFB00093; pc = 32'h100;
    ex_ready = 1'b1; mem_fwd_we = 1'b0; wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55;
    ex_fwd_data = 32'h0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
    m_ex = '0;
    cycle();
    cycle();
    n_vec++; if (act_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", act_ready); end
    n_vec++; if (dut_out() !== ex_t'('0)) begin n_err++; $display("FAIL reset_out: got %h want 0", dut_out()); end
    n_vec++;
    if ({if_ready16, ex_valid16, ex_op_a16, ex_op_b16, ex_sd16, ex_imm16, ex_pc16, ex_rd16, ex_alu16,
         ex_reg_we16, ex_mem_we16, ex_mem_re16, ex_br16, ex_jmp16, ex_ill16} !== '0) begin
      n_err++; $display("FAIL reset_out16: got valid=%b rd=%h op_a=%h want 0", ex_valid16, ex_rd16, ex_op_a16);
    end
    rst = 1'b0; quiet(); if_valid = 1'b0;
    cycle();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %b want 0", ex_valid); end
  endtask

  task automatic test_addi();
    quiet(); if_valid = 1'b1; instr = 32'hFFB00093; pc = 32'h100;
    cycle();
    n_vec++; if (act_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready: got %b want 1", act_ready); end
    n_vec++;
    if (ex_valid !== 1'b1 || ex_op_a !== 32'h0 || ex_imm !== 32'hFFFFFFFB || ex_rd !== 5'd1 ||
        ex_reg_we !== 1'b1 || ex_alu !== 4'b0000) begin
      n_err++; $display("FAIL addi: got v=%b a=%h imm=%h rd=%0d we=%b alu=%b want 1 0 fffffffb 1 1 0000",
                        ex_valid, ex_op_a, ex_imm, ex_rd, ex_reg_we, ex_alu);
    end
    n_vec++; if (dut_out() !== m_ex) begin n_err++; $display("FAIL addi_all: got %h want %h", dut_out(), m_ex); end
  endtask

  task automatic test_forward();
    quiet(); if_valid = 1'b1; instr = 32'h002081B3; pc = 32'h104; ex_fwd_data = 32'h11;
`ifdef ID_FORWARDING_EN
    cycle();
    n_vec++; if (act_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready: got %b want 1", act_ready); end
    n_vec++; if (ex_valid !== 1'b1 || ex_op_a !== 32'h11) begin
      n_err++; $display("FAIL fwd_ex: got v=%b a=%h want 1 11", ex_valid, ex_op_a); end
`else
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_vec++; if (act_ready !== 1'b0 || ex_valid !== 1'b0) begin
        n_err++; $display("FAIL raw_bubble%0d: got rdy=%b v=%b want 0 0", k, act_ready, ex_valid); end
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'h11;
    end
    mem_fwd_we = 1'b0; wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h22;
    cycle();
    n_vec++; if (act_ready !== 1'b1 || ex_valid !== 1'b1 || ex_op_a !== 32'h22) begin
      n_err++; $display("FAIL raw_wb: got rdy=%b v=%b a=%h want 1 1 22", act_ready, ex_valid, ex_op_a); end
`endif
    n_vec++; if (dut_out() !== m_ex) begin n_err++; $display("FAIL fwd_all: got %h want %h", dut_out(), m_ex); end
  endtask

  task automatic test_load_use();
    quiet(); if_valid = 1'b1; instr = 32'h0000A283; pc = 32'h200;
    cycle();
    n_vec++; if (ex_valid !== 1'b1 || ex_mem_re !== 1'b1 || ex_rd !== 5'd5) begin
      n_err++; $display("FAIL lw: got v=%b re=%b rd=%0d want 1 1 5", ex_valid, ex_mem_re, ex_rd); end
    instr = 32'h00528333; pc = 32'h204;
    cycle();
    n_vec++; if (act_ready !== 1'b0 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble: got rdy=%b v=%b want 0 0", act_ready, ex_valid); end
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hABCD;
`ifndef ID_FORWARDING_EN
    cycle();
    n_vec++; if (act_ready !== 1'b0 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble2: got rdy=%b v=%b want 0 0", act_ready, ex_valid); end
    mem_fwd_we = 1'b0; wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hABCD;
`endif
    cycle();
    n_vec++; if (act_ready !== 1'b1 || ex_valid !== 1'b1 || ex_op_a !== 32'hABCD || ex_op_b !== 32'hABCD) begin
      n_err++; $display("FAIL lu_data: got rdy=%b v=%b a=%h b=%h want 1 1 abcd abcd",
                        act_ready, ex_valid, ex_op_a, ex_op_b); end
    n_vec++; if (dut_out() !== m_ex) begin n_err++; $display("FAIL lu_all: got %h want %h", dut_out(), m_ex); end
  endtask

  task automatic test_backpressure();
    quiet(); if_valid = 1'b1; instr = 32'h00100393; pc = 32'h300;
    cycle();
    ex_ready = 1'b0; instr = 32'h00200413; pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_vec++; if (act_ready !== 1'b0 || ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_imm !== 32'h1 || ex_pc !== 32'h300) begin
        n_err++; $display("FAIL bp_hold%0d: got rdy=%b v=%b rd=%0d imm=%h pc=%h want 0 1 7 1 300",
                          k, act_ready, ex_valid, ex_rd, ex_imm, ex_pc); end
      n_vec++; if (dut_out() !== m_ex) begin n_err++; $display("FAIL bp_all%0d: got %h want %h", k, dut_out(), m_ex); end
    end
    ex_ready = 1'b1;
    cycle();
    n_vec++; if (act_ready !== 1'b1 || ex_rd !== 5'd8 || ex_imm !== 32'h2) begin
      n_err++; $display("FAIL bp_release: got rdy=%b rd=%0d imm=%h want 1 8 2", act_ready, ex_rd, ex_imm); end
  endtask

  task automatic test_flush();
    quiet(); if_valid = 1'b1; instr = 32'h0000A283; pc = 32'h400;
    cycle();
    instr = 32'h00528333; pc = 32'h404; flush = 1'b1;
    cycle();
    n_vec++; if (act_ready !== 1'b1 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: got rdy=%b v=%b want 1 0", act_ready, ex_valid); end
    flush = 1'b0; instr = 32'h00300493; pc = 32'h500;
    cycle();
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_pc !== 32'h500) begin
      n_err++; $display("FAIL flush_redirect: got v=%b rd=%0d pc=%h want 1 9 500", ex_valid, ex_rd, ex_pc); end
    ex_ready = 1'b0; flush = 1'b1;
    cycle();
    n_vec++; if (act_ready !== 1'b1 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_bp: got rdy=%b v=%b want 1 0", act_ready, ex_valid); end
    n_vec++; if (dut_out() !== m_ex) begin n_err++; $display("FAIL flush_all: got %h want %h", dut_out(), m_ex); end
  endtask

  task automatic test_regfile();
    quiet(); if_valid = 1'b0;
    cycle();
    cycle();
    if_valid = 1'b1; instr = 32'h00020513; pc = 32'h600;
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h1234;
    cycle();
    n_vec++; if (ex_op_a !== 32'h1234) begin n_err++; $display("FAIL wb_bypass: got %h want 1234", ex_op_a); end
    wb_waddr = 5'd0; wb_wdata = 32'hFFFF; instr = 32'h000001B3;
    cycle();
    wb_we = 1'b0;
    cycle();
    n_vec++; if (ex_op_a !== 32'h0 || ex_op_b !== 32'h0 || ex_op_a16 !== 32'h0 || ex_op_b16 !== 32'h0) begin
      n_err++; $display("FAIL x0_read: got a=%h b=%h a16=%h b16=%h want 0", ex_op_a, ex_op_b, ex_op_a16, ex_op_b16); end
    instr = 32'h002088B3;
    cycle();
    n_vec++; if (ex_valid16 !== 1'b1 || ex_ill16 !== 1'b1 || ex_reg_we16 !== 1'b0) begin
      n_err++; $display("FAIL rv32e_illegal: got v=%b ill=%b we=%b want 1 1 0", ex_valid16, ex_ill16, ex_reg_we16); end
    n_vec++; if (ex_ill !== 1'b0 || ex_reg_we !== 1'b1 || ex_rd !== 5'd17) begin
      n_err++; $display("FAIL rv32i_x17: got ill=%b we=%b rd=%0d want 0 1 17", ex_ill, ex_reg_we, ex_rd); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11];
    logic [31:0] w;
    opcs = '{OP, OPI, LD, ST, BR, JAL, JALR, LUI, AUIPC, 7'b1111111, 7'b0001111};
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(10, 0)];
    w[11:7]  = 5'($urandom_range(7, 0));
    w[19:15] = 5'($urandom_range(7, 0));
    w[24:20] = 5'($urandom_range(7, 0));
    return w;
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if_valid     = ($urandom_range(3, 0) != 0);
      instr        = rand_instr();
      pc           = $urandom;
      ex_ready     = ($urandom_range(9, 0) < 7);
      flush        = ($urandom_range(19, 0) == 0);
      ex_fwd_data  = $urandom;
      mem_fwd_we   = ($urandom_range(2, 0) == 0);
      mem_fwd_rd   = 5'($urandom_range(7, 0));
      mem_fwd_data = $urandom;
      wb_we        = $urandom_range(1, 0) == 1;
      wb_waddr     = 5'($urandom_range(7, 0));
      wb_wdata     = $urandom;
      cycle();
      n_vec++; if (act_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, act_ready, exp_ready); end
      n_vec++; if (dut_out() !== m_ex) begin
        n_err++; $display("FAIL rnd_ex[%0d]: got %h want %h", k, dut_out(), m_ex); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_regfile();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
